// File: rtl/reg_read_stage.sv
// Register-read stage: reads source/destination operands with writeback bypass,
// stalls on busy registers, and presents results from a back-pressure-holding register.
module reg_read_stage #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 64,
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 1,
  parameter int PAYLOAD_W = 512,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SRC*REG_W-1:0]    in_src_reg,
  input  logic [NUM_SRC-1:0]          in_src_valid,
  input  logic [REG_W-1:0]            in_dest_reg,
  input  logic                        in_dest_valid,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic [NUM_REGS*DATA_W-1:0]  regfile,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*REG_W-1:0]     wb_reg,
  input  logic [NUM_WB*DATA_W-1:0]    wb_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_SRC*DATA_W-1:0]   out_operand,
  output logic [NUM_SRC-1:0]          out_operand_valid,
  output logic [NUM_SRC*REG_W-1:0]    out_src_reg,
  output logic [REG_W-1:0]            out_dest_reg,
  output logic                        out_dest_valid,
  output logic [DATA_W-1:0]           out_dest_value,
  output logic [PAYLOAD_W-1:0]        out_payload,
  output logic [NUM_REGS-1:0]         busy
);

  // Returns {hit, data}; later ports overwrite earlier ones so the highest index wins.
  function automatic logic [DATA_W:0] wbLookup(
    input logic [REG_W-1:0]         code,
    input logic [NUM_WB-1:0]        wbV,
    input logic [NUM_WB*REG_W-1:0]  wbR,
    input logic [NUM_WB*DATA_W-1:0] wbD
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wbV[w] && wbR[w*REG_W +: REG_W] == code) res = {1'b1, wbD[w*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  logic [NUM_REGS-1:0]        busyReg, busyNext;
  logic                       outValidReg;
  logic [NUM_SRC*DATA_W-1:0]  operandReg;
  logic [NUM_SRC-1:0]         operandValidReg;
  logic [NUM_SRC*REG_W-1:0]   srcCodeReg;
  logic [REG_W-1:0]           destCodeReg;
  logic                       destValidReg;
  logic [DATA_W-1:0]          destValueReg;
  logic [PAYLOAD_W-1:0]       payloadReg;

  logic [NUM_SRC-1:0]         srcHazard;
  logic [NUM_SRC*DATA_W-1:0]  srcValue;
  logic [DATA_W:0]            destLookup;
  logic                       destHazard;
  logic [DATA_W-1:0]          destValue;
  logic                       accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : genSrc
      logic [REG_W-1:0] code;
      logic [DATA_W:0]  lookup;
      assign code   = in_src_reg[gi*REG_W +: REG_W];
      assign lookup = wbLookup(code, wb_valid, wb_reg, wb_data);
      assign srcHazard[gi] = in_src_valid[gi] && busyReg[code] && !lookup[DATA_W];
      assign srcValue[gi*DATA_W +: DATA_W] =
        !in_src_valid[gi] ? '0 :
        lookup[DATA_W]    ? lookup[DATA_W-1:0] :
                            regfile[code*DATA_W +: DATA_W];
    end
  endgenerate

  assign destLookup = wbLookup(in_dest_reg, wb_valid, wb_reg, wb_data);
  assign destHazard = in_dest_valid && busyReg[in_dest_reg] && !destLookup[DATA_W];
  assign destValue  = !in_dest_valid    ? '0 :
                      destLookup[DATA_W] ? destLookup[DATA_W-1:0] :
                                           regfile[in_dest_reg*DATA_W +: DATA_W];

  assign in_ready = !flush && !(|srcHazard) && !destHazard && (!outValidReg || out_ready);
  assign accept   = in_valid && in_ready;

  // Writebacks release registers; a new writer claims its register afterwards so set wins.
  always_comb begin
    busyNext = busyReg;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_valid[w]) busyNext[wb_reg[w*REG_W +: REG_W]] = 1'b0;
    end
    if (accept && in_dest_valid) busyNext[in_dest_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busyReg         <= '0;
      outValidReg     <= 1'b0;
      operandReg      <= '0;
      operandValidReg <= '0;
      srcCodeReg      <= '0;
      destCodeReg     <= '0;
      destValidReg    <= 1'b0;
      destValueReg    <= '0;
      payloadReg      <= '0;
    end else if (flush) begin
      busyReg     <= '0;
      outValidReg <= 1'b0;
    end else begin
      busyReg <= busyNext;
      if (accept) begin
        outValidReg     <= 1'b1;
        operandReg      <= srcValue;
        operandValidReg <= in_src_valid;
        srcCodeReg      <= in_src_reg;
        destCodeReg     <= in_dest_reg;
        destValidReg    <= in_dest_valid;
        destValueReg    <= destValue;
        payloadReg      <= in_payload;
      end else if (out_ready) begin
        outValidReg <= 1'b0;
      end
    end
  end

  assign out_valid         = outValidReg;
  assign out_operand       = operandReg;
  assign out_operand_valid = operandValidReg;
  assign out_src_reg       = srcCodeReg;
  assign out_dest_reg      = destCodeReg;
  assign out_dest_valid    = destValidReg;
  assign out_dest_value    = destValueReg;
  assign out_payload       = payloadReg;
  assign busy              = busyReg;

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Parametrised, registered register-read stage of the x86 pipeline, sitting between decode and execute. It accepts one decoded instruction per cycle over a valid/ready handshake and reads up to NUM_SRC source operands plus the destination's current value from the architectural register file. It resolves read-after-write and write-after-write hazards with a per-register busy scoreboard and forwards same-cycle writeback data. Results are presented one cycle later from an output register that holds under back-pressure.

## Interface
Parameters:
- NUM_REGS, 16, architectural registers; REG_W = $clog2(NUM_REGS)
- DATA_W, 64, register width
- NUM_SRC, 2, source operand ports
- NUM_WB, 1, writeback ports
- PAYLOAD_W, 512, opaque decoder fields passed through unchanged (RIP, opcode, imm/disp, lengths, memory/RIP-use flags)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle
- in_src_reg  in  NUM_SRC*REG_W  source register codes, port i at [i*REG_W +: REG_W]
- in_src_valid  in  NUM_SRC  per-source valid
- in_dest_reg  in  REG_W  destination register code
- in_dest_valid  in  1  instruction writes in_dest_reg
- in_payload  in  PAYLOAD_W  passthrough fields
- regfile  in  NUM_REGS*DATA_W  register file contents, reg r at [r*DATA_W +: DATA_W]
- wb_valid  in  NUM_WB  writeback port active
- wb_reg  in  NUM_WB*REG_W  writeback register codes
- wb_data  in  NUM_WB*DATA_W  writeback values
- flush  in  1  pipeline flush (branch mispredict/redirect)
- out_valid  out  1  registered result valid
- out_ready  in  1  execute consumes result
- out_operand  out  NUM_SRC*DATA_W  operand values
- out_operand_valid  out  NUM_SRC  copy of in_src_valid
- out_src_reg  out  NUM_SRC*REG_W  copy of source codes
- out_dest_reg  out  REG_W  copy of in_dest_reg
- out_dest_valid  out  1  copy of in_dest_valid
- out_dest_value  out  DATA_W  current value of destination register
- out_payload  out  PAYLOAD_W  copy of in_payload
- busy  out  NUM_REGS  scoreboard state

## Operation
- Source hit for a valid source s: some wb port w has wb_valid[w] and wb_reg[w] == src_reg[s].
- Source hazard: in_src_valid[s] && busy[src_reg[s]] && no hit.
- Dest hazard: in_dest_valid && busy[in_dest_reg] && no writeback to in_dest_reg this cycle.
- in_ready = !flush && no hazard on any source or dest && (!out_valid || out_ready). Combinational; does not depend on in_valid.
- Accept = in_valid && in_ready.
- Operand value: if there is a hit, take the wb_data of the matching port; the highest-index matching port wins. Otherwise read regfile. Invalid sources capture 0. out_dest_value follows the same rule, or 0 if the dest is invalid.
- Scoreboard, per cycle:
  - Each wb_valid[w] clears busy[wb_reg[w]].
  - Accept with in_dest_valid sets busy[in_dest_reg]. Set overrides a same-cycle clear of the same register.
- flush clears all busy bits and out_valid. It also blocks accept in the same cycle.

## Timing
- Reset (async assert, sync deassert): out_valid=0, busy=0, all out_* data/code fields=0. in_ready then follows its equation (1 when flush=0).
- Latency: 1 cycle from accept to out_valid=1 with captured data.
- Output hold: while out_valid && !out_ready, all out_* fields are stable and in_ready=0.
- Accept and out_ready in the same cycle: the output register reloads and there is no bubble. Full throughput is 1 instruction per cycle.
- out_valid && out_ready without accept: out_valid goes to 0 next cycle.
- Captured operands are final. Sources were non-busy or bypassed at accept, so no re-forwarding is done after capture.
- A busy bit set at accept is visible to the next cycle's hazard check. A back-to-back dependent instruction stalls until writeback, or is accepted in the writeback cycle via the bypass.
- reset_n asserted mid-stall: all state clears immediately and the held instruction is dropped.

## Test plan
- Reset: hold reset_n=0, then release with in_valid=0 -> out_valid=0, busy=0, in_ready=1.
- Independent stream: regfile[3]=0x11, regfile[5]=0x22; send src {3,5}, dest 7 -> next cycle out_operand={0x11,0x22}, busy[7]=1.
- RAW stall and bypass: dest 7 issued, then instruction with src 7 -> in_ready=0 until wb_valid with wb_reg=7, wb_data=0xABCD; in that cycle accept, and out_operand[0]=0xABCD while regfile[7] still holds the old value. busy[7]=0 afterwards, unless the new instruction also writes 7.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction loads in the same cycle with no bubble.
- WAW plus same-cycle clear: busy[2]=1; new dest 2 arrives with wb_reg=2 -> accepted, busy[2] remains 1.
- Flush: busy={2,7}, out_valid=1, flush=1 with in_valid=1 -> next cycle out_valid=0, busy=0, no accept in the flush cycle.
